// File: rtl/key_cond_pkg.sv
// Shared types and constants for the push-button conditioner.
package key_cond_pkg;

   typedef enum logic [1:0] {
      StUp,
      StWaitDown,
      StDown,
      StWaitUp
   } key_state_e;

   localparam int unsigned PressCountW = 8;
   localparam logic [PressCountW-1:0] PressCountMax = 8'd255;

endpackage

// File: rtl/key_debounce_channel.sv
// One push-button channel: two-flop synchronizer, debounce FSM with stability counter,
// registered active-low level and a one-cycle press pulse.
module key_debounce_channel
   import key_cond_pkg::*;
#(
   parameter int unsigned DebounceCycles = 1000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_raw_i,
   output logic key_level_o,
   output logic key_press_o
);

   localparam int unsigned CntW = $clog2(DebounceCycles);
   localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

   logic [1:0]      sync_q;
   logic            synced;
   key_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            level_q, level_d;
   logic            press_q, press_d;

   assign synced = sync_q[1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= 2'b11;
         state_q <= StUp;
         cnt_q   <= '0;
         level_q <= 1'b1;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], key_raw_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StUp: begin
            if (!synced) begin
               state_d = StWaitDown;
               cnt_d   = '0;
            end
         end
         StWaitDown: begin
            if (synced) begin
               state_d = StUp;
            end else if (cnt_q == CntLast) begin
               state_d = StDown;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDown: begin
            if (synced) begin
               state_d = StWaitUp;
               cnt_d   = '0;
            end
         end
         StWaitUp: begin
            if (!synced) begin
               state_d = StDown;
            end else if (cnt_q == CntLast) begin
               state_d = StUp;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StUp;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the FSM.
   always_comb begin
      level_d = (state_d == StUp) || (state_d == StWaitDown);
      press_d = (state_q == StWaitDown) && (state_d == StDown);
   end

   assign key_level_o = level_q;
   assign key_press_o = press_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounces NKEYS active-low push buttons and provides sticky capture flags and a
// saturating total press counter.
module key_conditioner
   import key_cond_pkg::*;
#(
   parameter int unsigned NKEYS           = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic                   CLOCK_50,
   input  logic                   reset_n,
   input  logic [NKEYS-1:0]       key_raw,
   output logic [NKEYS-1:0]       key_level,
   output logic [NKEYS-1:0]       key_press,
   output logic [NKEYS-1:0]       key_capture,
   input  logic [NKEYS-1:0]       capture_clr,
   output logic [PressCountW-1:0] press_count,
   input  logic                   count_clr
);

   logic [NKEYS-1:0]       capture_q, capture_d;
   logic [PressCountW-1:0] count_q, count_d;
   logic [PressCountW:0]   press_sum;
   logic [PressCountW+1:0] count_sum;

   for (genvar i = 0; i < NKEYS; i++) begin : g_chan
      key_debounce_channel #(
         .DebounceCycles(DEBOUNCE_CYCLES)
      ) u_chan (
         .clk_i      (CLOCK_50),
         .rst_ni     (reset_n),
         .key_raw_i  (key_raw[i]),
         .key_level_o(key_level[i]),
         .key_press_o(key_press[i])
      );
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         capture_q <= '0;
         count_q   <= '0;
      end else begin
         capture_q <= capture_d;
         count_q   <= count_d;
      end
   end

   // A press in the same cycle as a clear strobe wins.
   always_comb begin
      capture_d = (capture_q & ~capture_clr) | key_press;
   end

   always_comb begin
      press_sum = '0;
      for (int i = 0; i < NKEYS; i++) begin
         press_sum = press_sum + {{PressCountW{1'b0}}, key_press[i]};
      end
      count_sum = {2'b00, count_q} + {1'b0, press_sum};
      if (count_clr) begin
         count_d = press_sum[PressCountW-1:0];
      end else if (count_sum > {2'b00, PressCountMax}) begin
         count_d = PressCountMax;
      end else begin
         count_d = count_sum[PressCountW-1:0];
      end
   end

   assign key_capture = capture_q;
   assign press_count = count_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DEBOUNCE_CYCLES=4 and three keys.
module tb_key_conditioner;

   localparam int unsigned DB  = 4;
   localparam int unsigned LAT = DB + 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] key_raw = 3'b111;
   logic [2:0] capture_clr = 3'b000;
   logic       count_clr = 1'b0;
   logic [2:0] key_level, key_press, key_capture;
   logic [7:0] press_count;

   key_conditioner #(
      .NKEYS          (3),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .CLOCK_50   (clk),
      .reset_n    (rst_n),
      .key_raw    (key_raw),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_capture(key_capture),
      .capture_clr(capture_clr),
      .press_count(press_count),
      .count_clr  (count_clr)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      logic [2:0] press;
      int         stamp;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Called right after driving a raw edge at a negedge; the pulse is due LAT edges after
   // the first posedge that samples it.
   task automatic expect_press(input logic [2:0] p);
      exp_t e;
      e.press = p;
      e.stamp = edge_cnt + 1 + LAT;
      sb.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_round(input logic [2:0] p);
      key_raw = ~p;
      expect_press(p);
      cyc(LAT + 2);
      key_raw = 3'b111;
      cyc(LAT + 2);
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (key_press !== 3'b000) begin
         if (sb.size() == 0) begin
            check("unexpected_press", 32'(key_press), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("press_vec", 32'(key_press), 32'(mon_e.press));
            check("press_cycle", edge_cnt, mon_e.stamp);
            check("level_at_press", 32'(key_level & key_press), 32'd0);
         end
      end else if (sb.size() != 0 && sb[0].stamp < edge_cnt) begin
         check("missed_press", 32'(key_press), 32'(sb[0].press));
         void'(sb.pop_front());
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      cyc(2);
      check("rst_level", 32'(key_level), 32'h7);
      check("rst_press", 32'(key_press), 32'h0);
      check("rst_capture", 32'(key_capture), 32'h0);
      check("rst_count", 32'(press_count), 32'h0);
      rst_n = 1'b1;
      cyc(3);

      // Clean press on key 0
      key_raw[0] = 1'b0;
      expect_press(3'b001);
      cyc(LAT + 1);
      check("clean_level", 32'(key_level), 32'h6);
      cyc(1);
      check("clean_one_cycle", 32'(key_press), 32'h0);
      check("clean_capture", 32'(key_capture), 32'h1);
      check("clean_count", 32'(press_count), 32'h1);
      key_raw[0] = 1'b1;
      cyc(LAT + 2);
      check("release_level", 32'(key_level), 32'h7);
      check("release_count", 32'(press_count), 32'h1);
      count_clr = 1'b1;
      capture_clr = 3'b001;
      cyc(1);
      count_clr = 1'b0;
      capture_clr = 3'b000;
      check("clr_count", 32'(press_count), 32'h0);
      check("clr_capture", 32'(key_capture), 32'h0);

      // Bounce on key 1
      key_raw[1] = 1'b0; cyc(2);
      key_raw[1] = 1'b1; cyc(2);
      key_raw[1] = 1'b0; cyc(2);
      key_raw[1] = 1'b1; cyc(2);
      key_raw[1] = 1'b0;
      expect_press(3'b010);
      cyc(LAT + 2);
      check("bounce_level", 32'(key_level), 32'h5);
      check("bounce_capture", 32'(key_capture), 32'h2);
      check("bounce_count", 32'(press_count), 32'h1);
      key_raw[1] = 1'b1;
      cyc(LAT + 2);
      count_clr = 1'b1;
      capture_clr = 3'b111;
      cyc(1);
      count_clr = 1'b0;
      capture_clr = 3'b000;

      // Simultaneous press, clear strobe in the pulse cycle
      key_raw = 3'b000;
      expect_press(3'b111);
      cyc(LAT + 1);
      check("simul_level", 32'(key_level), 32'h0);
      capture_clr = 3'b111;
      cyc(1);
      capture_clr = 3'b000;
      check("simul_capture", 32'(key_capture), 32'h7);
      check("simul_count", 32'(press_count), 32'h3);
      key_raw = 3'b111;
      cyc(LAT + 2);

      // Saturation: 85*3 = 255 exactly, then 5 more presses
      count_clr = 1'b1;
      cyc(1);
      count_clr = 1'b0;
      for (int r = 0; r < 85; r++) press_round(3'b111);
      check("sat_exact", 32'(press_count), 32'd255);
      press_round(3'b111);
      check("sat_no_wrap", 32'(press_count), 32'd255);
      press_round(3'b001);
      press_round(3'b001);
      check("sat_260", 32'(press_count), 32'd255);
      key_raw[0] = 1'b0;
      expect_press(3'b001);
      cyc(LAT + 1);
      count_clr = 1'b1;
      cyc(1);
      count_clr = 1'b0;
      check("clr_with_press", 32'(press_count), 32'd1);
      key_raw = 3'b111;
      cyc(LAT + 2);

      // Reset two cycles into a key 2 debounce
      key_raw[2] = 1'b0;
      cyc(2);
      rst_n = 1'b0;
      #1;
      check("midrst_level", 32'(key_level), 32'h7);
      check("midrst_press", 32'(key_press), 32'h0);
      check("midrst_capture", 32'(key_capture), 32'h0);
      check("midrst_count", 32'(press_count), 32'h0);
      cyc(3);
      check("midrst_hold_level", 32'(key_level), 32'h7);
      rst_n = 1'b1;
      expect_press(3'b100);
      cyc(LAT + 1);
      check("postrst_level", 32'(key_level), 32'h3);
      cyc(1);
      check("postrst_count", 32'(press_count), 32'h1);

      cyc(4);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
